// File: rtl/branch_pc_unit.sv
// LC-3 branch/PC stage: BEN register, PC register, ADDR1/ADDR2 address adder, PCMUX.
// Optional build macro BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_ben,
    input  logic              ld_pc,
    input  logic [15:0]       ir,
    input  logic [2:0]        cc,
    input  logic [15:0]       sr1_data,
    input  logic [15:0]       bus,
    input  logic [1:0]        pcmux_sel,
    input  logic              addr1mux_sel,
    input  logic [1:0]        addr2mux_sel,
    output logic [15:0]       pc,
    output logic              ben,
    output logic [15:0]       addr_out
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] br_taken_cnt,
    output logic [STAT_W-1:0] br_not_taken_cnt
`endif
);

    localparam int unsigned DATA_W = 16;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic              ben_q, ben_d;
    logic              ben_next_c;
    logic [DATA_W-1:0] addr1_c, addr2_c;

    // Opcode bits are decoded by the control FSM, not here.
    logic unused_ir;
    assign unused_ir = ^ir[15:12];

    // Branch condition: any requested n/z/p flag matching the current condition code.
    assign ben_next_c = |(ir[11:9] & cc);

    // Address adder operand selection and sum (carry discarded).
    always_comb begin
        addr1_c = addr1mux_sel ? sr1_data : pc_q;
        addr2_c = '0;
        case (addr2mux_sel)
            2'd0:    addr2_c = '0;
            2'd1:    addr2_c = {{10{ir[5]}}, ir[5:0]};
            2'd2:    addr2_c = {{7{ir[8]}}, ir[8:0]};
            default: addr2_c = {{5{ir[10]}}, ir[10:0]};
        endcase
    end

    assign addr_out = DATA_W'(addr1_c + addr2_c);

    // Next-state for PC (PCMUX) and BEN; reserved PCMUX code holds PC.
    always_comb begin
        pc_d  = pc_q;
        ben_d = ben_q;
        if (ld_ben) begin
            ben_d = ben_next_c;
        end
        if (ld_pc) begin
            case (pcmux_sel)
                2'd0:    pc_d = DATA_W'(pc_q + DATA_W'(1));
                2'd1:    pc_d = bus;
                2'd2:    pc_d = addr_out;
                default: pc_d = pc_q;
            endcase
        end
    end

    // PC and BEN registers with synchronous reset taking priority over loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ben_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ben_q <= ben_d;
        end
    end

    assign pc  = pc_q;
    assign ben = ben_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_q, taken_d;
    logic [STAT_W-1:0] not_taken_q, not_taken_d;

    // Saturating branch outcome counters, bumped on every BEN load.
    always_comb begin
        taken_d     = taken_q;
        not_taken_d = not_taken_q;
        if (ld_ben) begin
            if (ben_next_c) begin
                if (!(&taken_q)) taken_d = STAT_W'(taken_q + STAT_W'(1));
            end else begin
                if (!(&not_taken_q)) not_taken_d = STAT_W'(not_taken_q + STAT_W'(1));
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_q     <= '0;
            not_taken_q <= '0;
        end else begin
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
        end
    end

    assign br_taken_cnt     = taken_q;
    assign br_not_taken_cnt = not_taken_q;
`else
    // Counter width only matters when statistics are built in.
    logic [STAT_W-1:0] unused_stat_w;
    assign unused_stat_w = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: scoreboard of expected pc/ben per clock edge.
module tb_branch_pc_unit;

    localparam int unsigned STAT_W   = 2;
    localparam logic [15:0] RESET_PC = 16'h3000;

    logic        clk = 1'b0;
    logic        rst_n, ld_ben, ld_pc, addr1mux_sel;
    logic [15:0] ir, sr1_data, bus;
    logic [2:0]  cc;
    logic [1:0]  pcmux_sel, addr2mux_sel;
    logic [15:0] pc, addr_out;
    logic        ben;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] br_taken_cnt, br_not_taken_cnt;
`endif

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        ben;
        int          taken;
        int          not_taken;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m_pc;
    logic        m_ben;
    int          m_taken, m_not_taken;

    branch_pc_unit #(.RESET_PC(RESET_PC), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ld_ben(ld_ben), .ld_pc(ld_pc),
        .ir(ir), .cc(cc), .sr1_data(sr1_data), .bus(bus),
        .pcmux_sel(pcmux_sel), .addr1mux_sel(addr1mux_sel), .addr2mux_sel(addr2mux_sel),
        .pc(pc), .ben(ben), .addr_out(addr_out)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(br_taken_cnt), .br_not_taken_cnt(br_not_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference address adder from the current inputs and model PC.
    function automatic logic [15:0] m_addr();
        logic [15:0] a1, a2;
        a1 = addr1mux_sel ? sr1_data : m_pc;
        case (addr2mux_sel)
            2'd0:    a2 = 16'h0000;
            2'd1:    a2 = {{10{ir[5]}}, ir[5:0]};
            2'd2:    a2 = {{7{ir[8]}}, ir[8:0]};
            default: a2 = {{5{ir[10]}}, ir[10:0]};
        endcase
        return a1 + a2;
    endfunction

    // Update the model for the coming edge, push the expectation, advance one cycle.
    task automatic apply_edge(input string name);
        exp_t        e;
        logic        bn;
        logic [15:0] a;
        int          sat;
        sat = (1 << STAT_W) - 1;
        bn  = (ir[11] & cc[2]) | (ir[10] & cc[1]) | (ir[9] & cc[0]);
        a   = m_addr();
        if (!rst_n) begin
            m_pc = RESET_PC; m_ben = 1'b0; m_taken = 0; m_not_taken = 0;
        end else begin
            if (ld_ben) begin
                m_ben = bn;
                if (bn) begin if (m_taken < sat) m_taken++; end
                else    begin if (m_not_taken < sat) m_not_taken++; end
            end
            if (ld_pc) begin
                case (pcmux_sel)
                    2'd0: m_pc = m_pc + 16'd1;
                    2'd1: m_pc = bus;
                    2'd2: m_pc = a;
                    default: ;
                endcase
            end
        end
        e.name = name; e.pc = m_pc; e.ben = m_ben;
        e.taken = m_taken; e.not_taken = m_not_taken;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; ld_pc = 1'b1; pcmux_sel = 2'd1; bus = 16'h1234;
        ld_ben = 1'b1; ir = 16'h0E00; cc = 3'b111;
        addr1mux_sel = 1'b0; addr2mux_sel = 2'd0;
        for (int i = 0; i < 2; i++) begin
            apply_edge("reset");
            e = sb_q.pop_front();
            checks++;
            if (pc !== 16'h3000 || ben !== 1'b0 || pc !== e.pc || ben !== e.ben) begin
                errors++;
                $display("FAIL %s: pc=%h ben=%b expected pc=%h ben=%b", e.name, pc, ben, e.pc, e.ben);
            end
        end
        checks++;
        if (addr_out !== 16'h3000) begin
            errors++;
            $display("FAIL reset_addr: addr_out=%h expected 3000", addr_out);
        end
        rst_n = 1'b1; ld_ben = 1'b0; pcmux_sel = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            apply_edge("incr_after_reset");
            e = sb_q.pop_front();
            checks++;
            if (pc !== 16'h3000 + 16'(i) || pc !== e.pc || ben !== e.ben) begin
                errors++;
                $display("FAIL %s: pc=%h expected %h", e.name, pc, 16'h3000 + 16'(i));
            end
        end
    endtask

    task automatic test_ben();
        exp_t   e;
        logic [2:0] cc_seq [3] = '{3'b010, 3'b100, 3'b010};
        logic       ld_seq [3] = '{1'b1, 1'b1, 1'b0};
        logic       want   [3] = '{1'b0, 1'b1, 1'b1};
        ld_pc = 1'b0; ir = 16'h0A05;
        for (int i = 0; i < 3; i++) begin
            cc = cc_seq[i]; ld_ben = ld_seq[i];
            apply_edge("ben_step");
            e = sb_q.pop_front();
            checks++;
            if (ben !== want[i] || ben !== e.ben || pc !== e.pc) begin
                errors++;
                $display("FAIL %s[%0d]: ben=%b pc=%h expected ben=%b pc=%h", e.name, i, ben, pc, want[i], e.pc);
            end
        end
        ld_ben = 1'b0;
    endtask

    task automatic test_branch_target();
        exp_t e;
        ld_pc = 1'b1; pcmux_sel = 2'd0;
        while (m_pc != 16'h3005) begin
            apply_edge("walk_to_3005");
            e = sb_q.pop_front();
            checks++;
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL %s: pc=%h expected %h", e.name, pc, e.pc);
            end
        end
        ld_pc = 1'b0; ir = 16'h0FFD; addr1mux_sel = 1'b0; addr2mux_sel = 2'd2; cc = 3'b010;
        #1;
        checks++;
        if (addr_out !== 16'h3002) begin
            errors++;
            $display("FAIL branch_addr: addr_out=%h expected 3002", addr_out);
        end
        ld_pc = 1'b1; pcmux_sel = 2'd2; ld_ben = 1'b1;
        apply_edge("branch_taken_load");
        e = sb_q.pop_front();
        checks++;
        if (pc !== 16'h3002 || ben !== 1'b1 || pc !== e.pc || ben !== e.ben) begin
            errors++;
            $display("FAIL %s: pc=%h ben=%b expected pc=3002 ben=1", e.name, pc, ben);
        end
        ld_ben = 1'b0; ld_pc = 1'b0;
    endtask

    task automatic test_jmp();
        exp_t e;
        logic [15:0] ir_v  [3] = '{16'h0000, 16'h003F, 16'h0400};
        logic [1:0]  sel_v [3] = '{2'd0, 2'd1, 2'd3};
        logic [15:0] want  [3] = '{16'h4000, 16'h3FFF, 16'h3C00};
        sr1_data = 16'h4000; addr1mux_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ir = ir_v[i]; addr2mux_sel = sel_v[i];
            #1;
            checks++;
            if (addr_out !== want[i] || addr_out !== m_addr()) begin
                errors++;
                $display("FAIL jmp_addr[%0d]: addr_out=%h expected %h", i, addr_out, want[i]);
            end
        end
        addr2mux_sel = 2'd0; ld_pc = 1'b1; pcmux_sel = 2'd2;
        apply_edge("jmp_load");
        e = sb_q.pop_front();
        checks++;
        if (pc !== 16'h4000 || pc !== e.pc) begin
            errors++;
            $display("FAIL %s: pc=%h expected 4000", e.name, pc);
        end
        ld_pc = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [1:0]  sel_v [4] = '{2'd1, 2'd0, 2'd3, 2'd1};
        logic        ld_v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] want  [4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        bus = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            pcmux_sel = sel_v[i]; ld_pc = ld_v[i];
            apply_edge("wrap_step");
            e = sb_q.pop_front();
            checks++;
            if (pc !== want[i] || pc !== e.pc) begin
                errors++;
                $display("FAIL %s[%0d]: pc=%h expected %h", e.name, i, pc, want[i]);
            end
        end
        ld_pc = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            ld_ben = 1'($urandom); ld_pc = 1'($urandom);
            ir = 16'($urandom); cc = 3'($urandom); sr1_data = 16'($urandom);
            bus = 16'($urandom); pcmux_sel = 2'($urandom);
            addr1mux_sel = 1'($urandom); addr2mux_sel = 2'($urandom);
            #1;
            checks++;
            if (addr_out !== m_addr()) begin
                errors++;
                $display("FAIL rand_addr[%0d]: addr_out=%h expected %h", i, addr_out, m_addr());
            end
            apply_edge("rand_edge");
            e = sb_q.pop_front();
            checks++;
            if (pc !== e.pc || ben !== e.ben) begin
                errors++;
                $display("FAIL %s[%0d]: pc=%h ben=%b expected pc=%h ben=%b", e.name, i, pc, ben, e.pc, e.ben);
            end
        end
        ld_ben = 1'b0; ld_pc = 1'b0;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        exp_t e;
        logic       rst_v [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] cc_v  [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
        int         tk_v  [8] = '{0, 1, 2, 3, 3, 3, 3, 0};
        int         nt_v  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        ir = 16'h0800; ld_ben = 1'b1; ld_pc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rst_n = rst_v[i]; cc = cc_v[i];
            apply_edge("stats_step");
            e = sb_q.pop_front();
            checks++;
            if (int'(br_taken_cnt) != tk_v[i] || int'(br_not_taken_cnt) != nt_v[i] ||
                int'(br_taken_cnt) != e.taken || int'(br_not_taken_cnt) != e.not_taken ||
                $isunknown({br_taken_cnt, br_not_taken_cnt})) begin
                errors++;
                $display("FAIL %s[%0d]: taken=%0d not_taken=%0d expected %0d %0d",
                         e.name, i, br_taken_cnt, br_not_taken_cnt, tk_v[i], nt_v[i]);
            end
        end
        rst_n = 1'b1; ld_ben = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; ld_ben = 1'b0; ld_pc = 1'b0; ir = '0; cc = '0;
        sr1_data = '0; bus = '0; pcmux_sel = '0; addr1mux_sel = 1'b0; addr2mux_sel = '0;
        m_pc = RESET_PC; m_ben = 1'b0; m_taken = 0; m_not_taken = 0;
        @(negedge clk);
        test_reset();
        test_ben();
        test_branch_target();
        test_jmp();
        test_wrap();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
